// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: controller states, receive
// buffer entry layout and line-control field positions.
package uart_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } rx_state_e;

  localparam int ENTRY_W  = 11;
  localparam int DATA_LSB = 0;
  localparam int PERR_BIT = 8;
  localparam int FERR_BIT = 9;
  localparam int BERR_BIT = 10;

  // Line-control register fields, same layout the engine decodes
  localparam int LCR_WLS_LSB = 0;
  localparam int LCR_WLS_W   = 2;
  localparam int LCR_STB_BIT = 2;
  localparam int LCR_PEN_BIT = 3;
  localparam int LCR_EPS_BIT = 4;
  localparam int LCR_SPS_BIT = 5;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic       berr,
                                                    input logic       ferr,
                                                    input logic       perr,
                                                    input logic [7:0] data);
    logic [ENTRY_W-1:0] e;
    e                       = '0;
    e[BERR_BIT]             = berr;
    e[FERR_BIT]             = ferr;
    e[PERR_BIT]             = perr;
    e[DATA_LSB +: 8]        = data;
    return e;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered storage and wrap-bit pointers; the head
// entry is read straight out of the array.
module uart_sync_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 11,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         wr, rd;

  assign level_o = wptr_q - rptr_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (level_o == '0);

  // A push into a full FIFO is only accepted when the head leaves this cycle
  assign rd = pop_i & ~empty_o;
  assign wr = push_i & (~full_o | rd);

  assign wptr_d  = wptr_q + (AW+1)'(wr);
  assign rptr_d  = rptr_q + (AW+1)'(rd);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: gates engine configuration changes to character
// boundaries, buffers received characters and raises overrun/watermark/timeout.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 11
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cfg_en,
  input  logic          cfg_wr,
  input  logic [15:0]   cfg_div,
  input  logic [7:0]    cfg_lcr,
  input  logic [7:0]    cfg_tmo,
  input  logic [AW:0]   cfg_wm,
  output logic          rx_en,
  output logic [15:0]   rx_div,
  output logic [7:0]    rx_lcr,
  input  logic          rx_valid,
  input  logic [7:0]    rx_bits,
  input  logic          rx_idle,
  input  logic          rx_perr,
  input  logic          rx_ferr,
  input  logic          rx_berr,
  output logic          rd_valid,
  output logic [W-1:0]  rd_data,
  input  logic          rd_ready,
  output logic [AW:0]   level,
  output logic          overrun,
  input  logic          clr_overrun,
  output logic          ip_wm,
  output logic          ip_tmo
);

  rx_state_e   state_q, state_d;
  logic [15:0] pend_div_q, pend_div_d;
  logic [7:0]  pend_lcr_q, pend_lcr_d;
  logic        pend_flag_q, pend_flag_d;
  logic [15:0] rx_div_q, rx_div_d;
  logic [7:0]  rx_lcr_q, rx_lcr_d;
  logic        overrun_q, overrun_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  bitcnt_q, bitcnt_d;
  logic        ip_tmo_q, ip_tmo_d;

  logic        safe, apply, clr_flag, run_c;
  logic        push, pop, full, empty, tmo_clr, bit_tick;
  logic [W-1:0] wdata;

  assign safe = rx_idle & ~rx_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= OFF;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:     if (cfg_en) state_d = RUN;
      RUN:     if (pend_flag_q || !cfg_en) state_d = HOLD;
      HOLD:    if (safe) state_d = cfg_en ? RUN : OFF;
      default: state_d = OFF;
    endcase
  end

  // OFF refreshes the active set at every idle point; HOLD only when a write is waiting
  always_comb begin
    run_c    = (state_q == RUN);
    apply    = safe & ((state_q == OFF) | ((state_q == HOLD) & pend_flag_q));
    clr_flag = safe & (state_q != RUN);
  end

  always_comb begin
    pend_div_d  = cfg_wr ? cfg_div : pend_div_q;
    pend_lcr_d  = cfg_wr ? cfg_lcr : pend_lcr_q;
    pend_flag_d = cfg_wr ? 1'b1 : (clr_flag ? 1'b0 : pend_flag_q);
    rx_div_d    = apply ? pend_div_q : rx_div_q;
    rx_lcr_d    = apply ? pend_lcr_q : rx_lcr_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_div_q  <= '0;
      pend_lcr_q  <= '0;
      pend_flag_q <= 1'b0;
      rx_div_q    <= '0;
      rx_lcr_q    <= '0;
    end else begin
      pend_div_q  <= pend_div_d;
      pend_lcr_q  <= pend_lcr_d;
      pend_flag_q <= pend_flag_d;
      rx_div_q    <= rx_div_d;
      rx_lcr_q    <= rx_lcr_d;
    end
  end

  assign rx_en  = run_c;
  assign rx_div = rx_div_q;
  assign rx_lcr = rx_lcr_q;

  assign push  = rx_valid;
  assign pop   = rd_valid & rd_ready;
  assign wdata = W'(pack_entry(rx_berr, rx_ferr, rx_perr, rx_bits));

  uart_sync_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rd_data),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rd_valid = ~empty;
  assign ip_wm    = (level > cfg_wm);

  // Setting beats a simultaneous clear so a drop is never lost
  assign overrun_d = (push & full & ~pop) ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
  assign overrun   = overrun_q;

  assign tmo_clr  = push | pop | empty | ~rx_idle | (cfg_tmo == 8'd0);
  assign bit_tick = (rx_div_q != 16'd0) && (presc_q == rx_div_q - 16'd1);

  always_comb begin
    presc_d  = presc_q;
    bitcnt_d = bitcnt_q;
    ip_tmo_d = ip_tmo_q;
    if (tmo_clr) begin
      presc_d  = '0;
      bitcnt_d = '0;
      ip_tmo_d = 1'b0;
    end else if (rx_div_q != 16'd0) begin
      if (bit_tick) begin
        presc_d = '0;
        if (bitcnt_q != 8'hFF) bitcnt_d = bitcnt_q + 8'd1;
        if (({1'b0, bitcnt_q} + 9'd1) >= {1'b0, cfg_tmo}) ip_tmo_d = 1'b1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
      presc_q   <= '0;
      bitcnt_q  <= '0;
      ip_tmo_q  <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      presc_q   <= presc_d;
      bitcnt_q  <= bitcnt_d;
      ip_tmo_q  <= ip_tmo_d;
    end
  end

  assign ip_tmo = ip_tmo_q;

endmodule
